// File: rtl/dps_strap_ctrl_pkg.sv
// Shared types and reset values for the DPS strap sequencer.
// Optional feature macro DPS_RESTRAP_EN is consumed by dps_strap_ctrl.
package dps_strap_ctrl_pkg;

    typedef enum logic [1:0] {
        SAMPLE = 2'd0,
        HOLD   = 2'd1,
        RUN    = 2'd2
    } dps_state_e;

    typedef enum logic {
        DpsModeJtag = 1'b0,
        DpsModeSpi  = 1'b1
    } dps_mode_e;

    localparam dps_mode_e  RstModeSpi    = DpsModeJtag;
    localparam logic       RstBootstrap  = 1'b0;
    localparam logic       RstStrapValid = 1'b0;
    localparam logic       RstSysRst     = 1'b1;
    localparam logic [1:0] RstStrapSync  = 2'b00;
    localparam logic       RstSrstN      = 1'b1;
    localparam logic       RstCsb        = 1'b1;

    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/dps_strap_ctrl_debounce.sv
// Pin synchronizer and strap debouncer for the DPS strap sequencer.
// dps_strap_debounce reports stable_o once its synchronized input has held still.
module dps_strap_sync #(
    parameter int               Width    = 1,
    parameter int               Stages   = 2,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Stages-1:0][Width-1:0] r_stage;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stage <= {Stages{ResetVal}};
        end else begin
            r_stage <= {r_stage[Stages-2:0], d_i};
        end
    end

    assign q_o = r_stage[Stages-1];

endmodule

module dps_strap_debounce
    import dps_strap_ctrl_pkg::*;
#(
    parameter int               Width          = 2,
    parameter int               SyncStages     = 2,
    parameter int               DebounceCycles = 16,
    parameter logic [Width-1:0] ResetVal       = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o,
    output logic             stable_o
);

    localparam int              CntW   = cnt_width(DebounceCycles - 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    logic [Width-1:0]      w_q;
    logic                  w_same;
    logic [SyncStages-1:0] r_fill;
    logic [Width-1:0]      r_prev;
    logic                  r_prev_vld;
    logic [CntW-1:0]       r_cnt;

    dps_strap_sync #(
        .Width   (Width),
        .Stages  (SyncStages),
        .ResetVal(ResetVal)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (d_i),
        .q_o  (w_q)
    );

    // Reset values still in the chain are not real pin samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fill <= '0;
        end else begin
            r_fill <= {r_fill[SyncStages-2:0], 1'b1};
        end
    end

    assign w_same = r_prev_vld && (w_q == r_prev);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prev     <= ResetVal;
            r_prev_vld <= 1'b0;
            r_cnt      <= '0;
        end else if (clr_i) begin
            r_prev     <= w_q;
            r_prev_vld <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_prev     <= w_q;
            r_prev_vld <= r_fill[SyncStages-1];
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != CntMax) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign q_o      = w_q;
    assign stable_o = !clr_i && w_same && (r_cnt == CntMax);

endmodule

// File: rtl/dps_strap_ctrl.sv
// DPS debug-port strap sequencer: latches mode/boot straps and gates core reset.
// Define DPS_RESTRAP_EN to allow an idle-SPI mode change while in RUN.
module dps_strap_ctrl
    import dps_strap_ctrl_pkg::*;
#(
    parameter int DebounceCycles = 16,
    parameter int HoldCycles     = 32,
    parameter int SyncStages     = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strap_mode_i,
    input  logic strap_boot_i,
    input  logic srst_ni,
    input  logic spi_csb_i,
    output logic mode_spi_o,
    output logic bootstrap_o,
    output logic strap_valid_o,
    output logic sys_rst_o
);

    localparam int               HoldW    = cnt_width(HoldCycles - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);

    dps_state_e       r_state;
    dps_mode_e        r_mode;
    logic             r_boot;
    logic             r_valid;
    logic             r_sys_rst;
    logic [HoldW-1:0] r_hold_cnt;

    logic [1:0] w_strap;
    logic       w_stable;
    logic       w_srst_n;
    logic       w_clr;
    logic       w_restrap;

    dps_strap_sync #(
        .Width   (1),
        .Stages  (SyncStages),
        .ResetVal(RstSrstN)
    ) u_srst_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (srst_ni),
        .q_o  (w_srst_n)
    );

`ifdef DPS_RESTRAP_EN
    logic w_csb;

    dps_strap_sync #(
        .Width   (1),
        .Stages  (SyncStages),
        .ResetVal(RstCsb)
    ) u_csb_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (spi_csb_i),
        .q_o  (w_csb)
    );

    // SPI traffic shares the pins, so only an idle bus may count toward a restrap.
    assign w_clr     = !w_srst_n || ((r_state == RUN) && !w_csb);
    assign w_restrap = (r_state == RUN) && w_csb && w_stable &&
                       (w_strap[0] != r_mode);
`else
    logic w_unused_csb;

    assign w_unused_csb = spi_csb_i;
    assign w_clr        = !w_srst_n;
    assign w_restrap    = 1'b0;
`endif

    dps_strap_debounce #(
        .Width         (2),
        .SyncStages    (SyncStages),
        .DebounceCycles(DebounceCycles),
        .ResetVal      (RstStrapSync)
    ) u_strap_db (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (w_clr),
        .d_i     ({strap_boot_i, strap_mode_i}),
        .q_o     (w_strap),
        .stable_o(w_stable)
    );

    // Mode/boot keep their value across srst so the pin mux never glitches.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= SAMPLE;
            r_mode     <= RstModeSpi;
            r_boot     <= RstBootstrap;
            r_valid    <= RstStrapValid;
            r_sys_rst  <= RstSysRst;
            r_hold_cnt <= '0;
        end else if (!w_srst_n) begin
            r_state    <= SAMPLE;
            r_valid    <= 1'b0;
            r_sys_rst  <= 1'b1;
            r_hold_cnt <= '0;
        end else begin
            unique case (r_state)
                SAMPLE: begin
                    if (w_stable) begin
                        r_mode     <= dps_mode_e'(w_strap[0]);
                        r_boot     <= w_strap[1];
                        r_valid    <= 1'b1;
                        r_hold_cnt <= '0;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_hold_cnt == HoldLast) begin
                        r_state   <= RUN;
                        r_sys_rst <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (w_restrap) begin
                        r_mode     <= dps_mode_e'(w_strap[0]);
                        r_boot     <= w_strap[1];
                        r_sys_rst  <= 1'b1;
                        r_hold_cnt <= '0;
                        r_state    <= HOLD;
                    end
                end
                default: begin
                    r_state <= SAMPLE;
                end
            endcase
        end
    end

    assign mode_spi_o    = r_mode;
    assign bootstrap_o   = r_boot;
    assign strap_valid_o = r_valid;
    assign sys_rst_o     = r_sys_rst;

endmodule

// File: tb/tb_dps_strap_ctrl.sv
// Bench for dps_strap_ctrl: directed strap scenarios plus random pin activity.
// Expected outputs come from a window-over-pin-history reference model.
module tb_dps_strap_ctrl;

    localparam int DebounceCycles = 16;
    localparam int HoldCycles     = 32;
    localparam int SyncStages     = 2;
    localparam int Lat            = SyncStages + DebounceCycles;
    localparam int MaxCyc         = 8192;
    localparam int PhSample       = 0;
    localparam int PhHold         = 1;
    localparam int PhRun          = 2;

    logic clk = 1'b0;
    logic rst_i;
    logic strap_mode_i;
    logic strap_boot_i;
    logic srst_ni;
    logic spi_csb_i;
    logic mode_spi_o;
    logic bootstrap_o;
    logic strap_valid_o;
    logic sys_rst_o;

    always #5 clk = ~clk;

    dps_strap_ctrl #(
        .DebounceCycles(DebounceCycles),
        .HoldCycles    (HoldCycles),
        .SyncStages    (SyncStages)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .strap_mode_i (strap_mode_i),
        .strap_boot_i (strap_boot_i),
        .srst_ni      (srst_ni),
        .spi_csb_i    (spi_csb_i),
        .mode_spi_o   (mode_spi_o),
        .bootstrap_o  (bootstrap_o),
        .strap_valid_o(strap_valid_o),
        .sys_rst_o    (sys_rst_o)
    );

    int errors = 0;
    int checks = 0;
    int k      = 0;

    // Raw pin history, one entry per rising edge.
    bit h_rst [MaxCyc];
    bit h_mode[MaxCyc];
    bit h_boot[MaxCyc];
    bit h_srst[MaxCyc];
    bit h_csb [MaxCyc];

    int m_phase      = PhSample;
    bit m_mode       = 1'b0;
    bit m_boot       = 1'b0;
    bit m_valid      = 1'b0;
    bit m_sysrst     = 1'b1;
    int m_hold_start = 0;
    int m_epoch      = 0;
    int m_rst_edge   = -1000;

    // A latch needs DebounceCycles+1 identical raw samples, all taken after
    // the last clearing event, ending SyncStages edges before the latch.
    function automatic bit window_ok(input int e);
        int s;
        s = e - SyncStages;
        if (e - Lat < m_epoch) return 1'b0;
        for (int j = e - Lat; j <= s; j++) begin
            if (h_mode[j] != h_mode[s] || h_boot[j] != h_boot[s]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic latch(input int e);
        m_mode       = h_mode[e - SyncStages];
        m_boot       = h_boot[e - SyncStages];
        m_valid      = 1'b1;
        m_phase      = PhHold;
        m_hold_start = e;
    endtask

    task automatic model_edge(input int e);
        int s;
        s = e - SyncStages;
        if (h_rst[e]) begin
            m_phase    = PhSample;
            m_mode     = 1'b0;
            m_boot     = 1'b0;
            m_valid    = 1'b0;
            m_sysrst   = 1'b1;
            m_rst_edge = e;
            m_epoch    = e + 1;
        end else begin
            if (!h_srst[e] && (e + 1 > m_epoch)) m_epoch = e + 1;
            if (s > m_rst_edge && !h_srst[s]) begin
                m_phase  = PhSample;
                m_valid  = 1'b0;
                m_sysrst = 1'b1;
            end else if (m_phase == PhSample) begin
                if (window_ok(e)) latch(e);
            end else if (m_phase == PhHold) begin
                if (e == m_hold_start + HoldCycles) begin
                    m_phase  = PhRun;
                    m_sysrst = 1'b0;
                end
            end else begin
`ifdef DPS_RESTRAP_EN
                if (s > m_rst_edge && !h_csb[s]) begin
                    if (e - 1 > m_epoch) m_epoch = e - 1;
                end else if (window_ok(e) && (h_mode[s] != m_mode)) begin
                    latch(e);
                    m_sysrst = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s edge %0d: observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        h_rst[k]  = rst_i;
        h_mode[k] = strap_mode_i;
        h_boot[k] = strap_boot_i;
        h_srst[k] = srst_ni;
        h_csb[k]  = spi_csb_i;
        model_edge(k);
        @(negedge clk);
        chk("model_mode", mode_spi_o, m_mode);
        chk("model_boot", bootstrap_o, m_boot);
        chk("model_valid", strap_valid_o, m_valid);
        chk("model_sysrst", sys_rst_o, m_sysrst);
        k++;
    endtask

    initial begin
        int strap_left;
        int srst_left;
        int csb_left;

        rst_i        = 1'b1;
        strap_mode_i = 1'b1;
        strap_boot_i = 1'b1;
        srst_ni      = 1'b1;
        spi_csb_i    = 1'b1;

        // Reset state and first strap latch.
        step();
        chk("rst_mode", mode_spi_o, 1'b0);
        chk("rst_boot", bootstrap_o, 1'b0);
        chk("rst_valid", strap_valid_o, 1'b0);
        chk("rst_sysrst", sys_rst_o, 1'b1);
        step();
        step();
        rst_i = 1'b0;
        repeat (Lat) step();
        chk("latch_early", strap_valid_o, 1'b0);
        step();
        chk("latch_valid", strap_valid_o, 1'b1);
        chk("latch_mode", mode_spi_o, 1'b1);
        chk("latch_boot", bootstrap_o, 1'b1);
        chk("hold_sysrst", sys_rst_o, 1'b1);
        repeat (HoldCycles - 1) step();
        chk("hold_last", sys_rst_o, 1'b1);
        step();
        chk("run_sysrst", sys_rst_o, 1'b0);
        repeat (5) step();

        // One-cycle srst in RUN.
        srst_ni = 1'b0;
        step();
        srst_ni = 1'b1;
        step();
        step();
        chk("srst_sysrst", sys_rst_o, 1'b1);
        chk("srst_valid", strap_valid_o, 1'b0);
        chk("srst_mode_kept", mode_spi_o, 1'b1);
        repeat (Lat + HoldCycles + 2) step();
        chk("reseq_valid", strap_valid_o, 1'b1);
        chk("reseq_sysrst", sys_rst_o, 1'b0);

        // rst_i asserted mid-HOLD.
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        repeat (30) step();
        chk("midhold_state", strap_valid_o, 1'b1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("midhold_mode", mode_spi_o, 1'b0);
        chk("midhold_boot", bootstrap_o, 1'b0);
        chk("midhold_valid", strap_valid_o, 1'b0);
        chk("midhold_sysrst", sys_rst_o, 1'b1);

        // Mode toggling every 10 cycles never latches.
        strap_boot_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            strap_mode_i = i[0];
            repeat (10) step();
        end
        chk("toggle_valid", strap_valid_o, 1'b0);
        chk("toggle_sysrst", sys_rst_o, 1'b1);
        strap_mode_i = 1'b0;
        repeat (Lat) step();
        chk("settle_early", strap_valid_o, 1'b0);
        step();
        chk("settle_valid", strap_valid_o, 1'b1);
        chk("settle_mode", mode_spi_o, 1'b0);
        repeat (HoldCycles) step();
        chk("settle_run", sys_rst_o, 1'b0);

        // Mode flip in RUN, first with SPI busy, then idle.
        spi_csb_i    = 1'b0;
        strap_mode_i = 1'b1;
        repeat (40) step();
        chk("busy_mode", mode_spi_o, 1'b0);
        chk("busy_sysrst", sys_rst_o, 1'b0);
        spi_csb_i = 1'b1;
        repeat (Lat) step();
        chk("idle_early", mode_spi_o, 1'b0);
        step();
`ifdef DPS_RESTRAP_EN
        chk("restrap_mode", mode_spi_o, 1'b1);
        chk("restrap_sysrst", sys_rst_o, 1'b1);
`else
        chk("restrap_mode", mode_spi_o, 1'b0);
        chk("restrap_sysrst", sys_rst_o, 1'b0);
`endif
        repeat (HoldCycles - 1) step();
`ifdef DPS_RESTRAP_EN
        chk("restrap_hold", sys_rst_o, 1'b1);
`else
        chk("restrap_hold", sys_rst_o, 1'b0);
`endif
        step();
        chk("restrap_run", sys_rst_o, 1'b0);

        // srst held low across the debounce window.
        srst_ni = 1'b0;
        repeat (30) step();
        chk("srst_hold_valid", strap_valid_o, 1'b0);
        chk("srst_hold_sysrst", sys_rst_o, 1'b1);
        srst_ni = 1'b1;
        repeat (Lat) step();
        chk("srst_rel_early", strap_valid_o, 1'b0);
        step();
        chk("srst_rel_valid", strap_valid_o, 1'b1);
        chk("srst_rel_mode", mode_spi_o, 1'b1);
        chk("srst_rel_boot", bootstrap_o, 1'b0);

        // Random pin activity against the model.
        strap_left = 0;
        srst_left  = 0;
        csb_left   = 0;
        for (int i = 0; i < 2000; i++) begin
            rst_i = ($urandom_range(0, 599) == 0);
            if (strap_left == 0) begin
                strap_mode_i = 1'($urandom_range(0, 1));
                strap_boot_i = 1'($urandom_range(0, 1));
                strap_left   = $urandom_range(1, 45);
            end else begin
                strap_left--;
            end
            if (srst_left > 0) begin
                srst_ni = 1'b0;
                srst_left--;
            end else begin
                srst_ni = 1'b1;
                if ($urandom_range(0, 199) == 0) srst_left = $urandom_range(1, 25);
            end
            if (csb_left > 0) begin
                spi_csb_i = 1'b0;
                csb_left--;
            end else begin
                spi_csb_i = 1'b1;
                if ($urandom_range(0, 99) == 0) csb_left = $urandom_range(1, 30);
            end
            step();
        end
        rst_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
